int_to_flt: RTL
===============

Name: int_to_flt

Overview:
- Multi-cycle converter that sits directly upstream of the float+float adder.
- Reads a 16-bit two's-complement integer from data_mem and converts it to the team's 16-bit float format.
- Float format: sign[15], exp[14:10] with bias 15 (exp 0 means zero, no subnormals), mant[9:0] with a hidden 1.
- Writes the result back to data_mem as an addend the adder loads (default addresses 128..129).
- Drives the standard data_mem port set.
- Normalization is serial: one bit per cycle.

Parameters:
SRC_ADDR, 64, address of integer high byte; low byte at SRC_ADDR+1
DST_ADDR, 128, address of float high byte {sign,exp,mant[9:8]}; low byte mant[7:0] at DST_ADDR+1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; starts a conversion when sampled in IDLE or DONE
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE; held until the next start or reset
DataAddress  out  8  data_mem address
ReadMem  out  1  data_mem read enable
WriteMem  out  1  data_mem write enable; memory writes at posedge
DataIn  out  8  write data to data_mem
DataOut  in  8  read data from data_mem; combinational from DataAddress while ReadMem=1

Behaviour:
- Reset state: FSM=IDLE; busy=0, done=0, ReadMem=0, WriteMem=0, DataAddress=0, DataIn=0; internal mag/exp/sign cleared.
- States, in order: IDLE, RD_HI, RD_LO, ABS, NORM, ROUND, WR_HI, WR_LO, DONE.
- IDLE/DONE: start=1 at a posedge -> RD_HI; done drops in the same edge. start is ignored in all other states.
- RD_HI: DataAddress=SRC_ADDR, ReadMem=1; capture DataOut into x[15:8] at the edge.
- RD_LO: DataAddress=SRC_ADDR+1, ReadMem=1; capture x[7:0].
- ABS: sign=x[15]; mag=|x| as 16-bit unsigned (-32768 -> 0x8000, no overflow); exp=30.
  - If mag==0: zero flag set, go to ROUND (NORM skipped).
  - Else if mag[15]=1, go to ROUND; otherwise go to NORM.
- NORM: each cycle mag<<=1 and exp--; leave to ROUND when the shifted mag[15]=1.
  - k = 15 - p cycles, where p is the leading-one index of |x|; k ranges 0..15.
- ROUND: mant=mag[14:5], guard=mag[4], sticky=|mag[3:0].
  - Round to nearest even: increment when guard & (sticky | mant[0]).
  - Carry out of mant -> mant=0, exp++.
  - Exp stays <=30 for all inputs; exp=31 is unreachable. No saturation logic is needed, but an assertion must flag it.
  - Zero flag forces result 0x0000, including sign=0. There is no -0.
- WR_HI: DataAddress=DST_ADDR, WriteMem=1, DataIn={sign,exp[4:0],mant[9:8]}.
- WR_LO: DataAddress=DST_ADDR+1, WriteMem=1, DataIn=mant[7:0].
- DONE: done=1; all memory enables 0.
- ReadMem and WriteMem are never high together. Both are 0 in ABS, NORM and ROUND.
- Latency: start edge -> done=1 takes 7+k cycles. Zero input and |x| in [32768,65535] give 7; x=±1 gives 22.
- Reset mid-operation: next state IDLE, enables dropped the same edge.
  - A completed WR_HI is not undone; no further writes occur.
  - done=0 until a full conversion completes.
- Back-to-back: start in DONE re-reads SRC_ADDR, so changed memory contents are picked up.

Test Plan:
- x=0x0001 -> mem[128..129]=0x3C,0x00; done rises 22 cycles after start.
- x=0xFFFF (-1) -> 0xBC00; x=0x0000 -> 0x0000 with latency 7; x=0x8000 (-32768) -> 0xF800 with latency 7.
- Rounding: x=2049 -> 0x6800 (tie, even, no increment); x=2051 -> 0x6802 (round up); x=32767 -> 0x7800 (carry out, exp 29->30).
- Protocol: assert start while busy (ignored; single write pair observed).
  - Check ReadMem high only in RD_HI/RD_LO and WriteMem only in WR_HI/WR_LO, each for exactly 1 cycle, at the correct addresses.
- Reset asserted in the 3rd NORM cycle for x=1 -> IDLE next cycle; no writes to 128..129; done=0.
  - Then start a conversion of x=1000 -> 0x63D0.
- Chain with the adder: convert 3 to 128..129 and 5 to 130..131 (DST_ADDR overridden), then run the adder -> 132..133 = 0x4800 (8.0).

Source files
------------

// File: rtl/int_to_flt.sv
// int_to_flt: reads a 16-bit two's-complement integer from data_mem,
// converts it to the 16-bit float format {sign, exp[4:0] bias 15, mant[9:0]}
// with serial one-bit-per-cycle normalization and round-to-nearest-even,
// then writes the result back as two bytes for the float adder to load.
module int_to_flt #(
    parameter logic [7:0] SRC_ADDR = 8'd64,
    parameter logic [7:0] DST_ADDR = 8'd128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] DataAddress,
    output logic       ReadMem,
    output logic       WriteMem,
    output logic [7:0] DataIn,
    input  logic [7:0] DataOut
);

    typedef enum logic [3:0] {
        IDLE, RD_HI, RD_LO, ABS, NORM, ROUND, WR_HI, WR_LO, DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_x;
    logic [15:0] r_mag;
    logic [4:0]  r_exp;
    logic        r_sign;
    logic        r_zero;
    logic [9:0]  r_mant;

    logic [15:0] w_abs;
    logic [9:0]  w_mant_t;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [10:0] w_mant_sum;
    logic        w_carry;
    logic [5:0]  w_exp_sum;
    logic [15:0] w_res;

    // magnitude and round-to-nearest-even result from the current registers
    always_comb begin
        w_abs      = r_x[15] ? (~r_x + 16'd1) : r_x;
        w_mant_t   = r_mag[14:5];
        w_guard    = r_mag[4];
        w_sticky   = |r_mag[3:0];
        w_inc      = w_guard & (w_sticky | w_mant_t[0]);
        w_mant_sum = {1'b0, w_mant_t} + {10'd0, w_inc};
        w_carry    = w_mant_sum[10];
        w_exp_sum  = {1'b0, r_exp} + {5'd0, w_carry};
        // on carry-out the low ten bits of the sum are already zero
        w_res      = r_zero ? 16'h0000
                            : {r_sign, w_exp_sum[4:0], w_mant_sum[9:0]};
    end

    // conversion FSM with registered memory-port and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_mag       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_mant      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            DataAddress <= '0;
            ReadMem     <= 1'b0;
            WriteMem    <= 1'b0;
            DataIn      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= RD_HI;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        DataAddress <= SRC_ADDR;
                        ReadMem     <= 1'b1;
                    end
                end
                RD_HI: begin
                    r_x[15:8]   <= DataOut;
                    r_state     <= RD_LO;
                    DataAddress <= SRC_ADDR + 8'd1;
                end
                RD_LO: begin
                    r_x[7:0]    <= DataOut;
                    r_state     <= ABS;
                    ReadMem     <= 1'b0;
                    DataAddress <= '0;
                end
                ABS: begin
                    r_sign <= r_x[15];
                    r_mag  <= w_abs;
                    r_exp  <= 5'd30;
                    r_zero <= (w_abs == 16'd0);
                    if ((w_abs == 16'd0) || w_abs[15])
                        r_state <= ROUND;
                    else
                        r_state <= NORM;
                end
                NORM: begin
                    r_mag <= {r_mag[14:0], 1'b0};
                    r_exp <= r_exp - 5'd1;
                    if (r_mag[14])
                        r_state <= ROUND;
                end
                ROUND: begin
                    r_exp       <= w_exp_sum[4:0];
                    r_mant      <= w_res[9:0];
                    r_state     <= WR_HI;
                    DataAddress <= DST_ADDR;
                    WriteMem    <= 1'b1;
                    DataIn      <= w_res[15:8];
                end
                WR_HI: begin
                    r_state     <= WR_LO;
                    DataAddress <= DST_ADDR + 8'd1;
                    DataIn      <= r_mant[7:0];
                end
                WR_LO: begin
                    r_state     <= DONE;
                    WriteMem    <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    DataAddress <= '0;
                    DataIn      <= '0;
                end
                default: begin
                    r_state  <= IDLE;
                    busy     <= 1'b0;
                    ReadMem  <= 1'b0;
                    WriteMem <= 1'b0;
                end
            endcase
        end
    end

    // exponent 31 can never be produced by a 16-bit integer input
    always_ff @(posedge clk) begin
        if (!reset && (r_state == ROUND))
            assert (r_zero || (w_exp_sum < 6'd31));
    end

endmodule
